// File: rtl/wb_rr_arbiter_pkg.sv
// Shared Wishbone interconnect definitions: arbiter FSM states, CTI codes and
// the watchdog counter width helper.
package wb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // A disabled watchdog (limit 0) still gets a 1-bit counter so no vector is empty.
  function automatic int wdog_width(input int limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between N Wishbone masters, the round-robin arbiter and the
// shared slave. Master vectors are flattened, master 0 in the LSBs.
interface wb_rr_arbiter_if #(
  parameter int num_masters = 2,
  parameter int aw          = 32,
  parameter int dw          = 32
);
  logic [num_masters*aw-1:0]     wbm_adr_i;
  logic [num_masters*dw-1:0]     wbm_dat_i;
  logic [num_masters*dw/8-1:0]   wbm_sel_i;
  logic [num_masters-1:0]        wbm_we_i;
  logic [num_masters-1:0]        wbm_cyc_i;
  logic [num_masters-1:0]        wbm_stb_i;
  logic [num_masters*3-1:0]      wbm_cti_i;
  logic [num_masters*2-1:0]      wbm_bte_i;
  logic [num_masters*dw-1:0]     wbm_dat_o;
  logic [num_masters-1:0]        wbm_ack_o;
  logic [num_masters-1:0]        wbm_err_o;
  logic [num_masters-1:0]        wbm_rty_o;

  logic [aw-1:0]                 wbs_adr_o;
  logic [dw-1:0]                 wbs_dat_o;
  logic [dw/8-1:0]               wbs_sel_o;
  logic                          wbs_we_o;
  logic                          wbs_cyc_o;
  logic                          wbs_stb_o;
  logic [2:0]                    wbs_cti_o;
  logic [1:0]                    wbs_bte_o;
  logic [dw-1:0]                 wbs_dat_i;
  logic                          wbs_ack_i;
  logic                          wbs_err_i;
  logic                          wbs_rty_i;

  // Arbiter view: sink of master requests, source of slave requests.
  modport arb (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
           wbm_cti_i, wbm_bte_i, wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
           wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
           wbs_cti_o, wbs_bte_o
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
           wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o
  );

  modport slave (
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
           wbs_cti_o, wbs_bte_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );
endinterface

// File: rtl/wb_rr_pick.sv
// Rotating priority encoder: first set bit of req searching upward from ptr,
// wrapping modulo num_masters.
module wb_rr_pick #(
  parameter int num_masters = 2
) (
  input  logic [num_masters-1:0]         req,
  input  logic [$clog2(num_masters)-1:0] ptr,
  output logic [$clog2(num_masters)-1:0] idx,
  output logic                           valid
);
  localparam int iw = $clog2(num_masters);

  logic [iw-1:0] cand;

  // Walk from farthest to nearest so the closest requester to ptr is written last.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path infers a latch.
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = num_masters - 1; i >= 0; i--) begin
      cand = iw'((int'(ptr) + i) % num_masters);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin, cycle-holding Wishbone arbiter with a per-beat watchdog that
// terminates a stuck transfer with err and releases the shared slave.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int num_masters = 2,
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int timeout     = 255
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  wb_rr_arbiter_if.arb           bus,
  output logic [num_masters-1:0] grant_o,
  output logic                   timeout_o
);
  localparam int iw = $clog2(num_masters);
  localparam int cw = wdog_width(timeout);
  localparam int sw = dw / 8;
  localparam logic [cw-1:0] last_cnt = cw'(timeout - 1);
  localparam logic [iw-1:0] last_idx = iw'(num_masters - 1);

  arb_state_t             state, state_n;
  logic [iw-1:0]          gnt, gnt_n, ptr, ptr_n, gnt_inc, pick_idx;
  logic [cw-1:0]          cnt, cnt_n;
  logic                   pick_valid, cyc_g, stb_g, term, cyc_o, stb_o;
  logic [num_masters-1:0] ack_v, err_v, rty_v;

  wb_rr_pick #(.num_masters(num_masters)) u_pick (
    .req   (bus.wbm_cyc_i),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign cyc_g   = bus.wbm_cyc_i[gnt];
  assign stb_g   = bus.wbm_stb_i[gnt];
  assign term    = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
  assign gnt_inc = (gnt == last_idx) ? '0 : gnt + 1'b1;

  // Request fields always follow the owner; only cyc/stb are gated by state.
  assign bus.wbs_adr_o = bus.wbm_adr_i[int'(gnt)*aw +: aw];
  assign bus.wbs_dat_o = bus.wbm_dat_i[int'(gnt)*dw +: dw];
  assign bus.wbs_sel_o = bus.wbm_sel_i[int'(gnt)*sw +: sw];
  assign bus.wbs_cti_o = bus.wbm_cti_i[int'(gnt)*3 +: 3];
  assign bus.wbs_bte_o = bus.wbm_bte_i[int'(gnt)*2 +: 2];
  assign bus.wbs_we_o  = bus.wbm_we_i[gnt];
  assign bus.wbs_cyc_o = cyc_o;
  assign bus.wbs_stb_o = stb_o;
  assign bus.wbm_dat_o = {num_masters{bus.wbs_dat_i}};
  assign bus.wbm_ack_o = ack_v;
  assign bus.wbm_err_o = err_v;
  assign bus.wbm_rty_o = rty_v;

  always_ff @(posedge wb_clk_i) begin
    // NOTE: non-blocking updates so every register samples pre-edge values.
    if (!wb_rst_n_i) begin
      state <= ST_IDLE;
      gnt   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    ptr_n     = ptr;
    cnt_n     = '0;
    cyc_o     = 1'b0;
    stb_o     = 1'b0;
    ack_v     = '0;
    err_v     = '0;
    rty_v     = '0;
    timeout_o = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_n   = pick_idx;
          state_n = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cyc_o      = cyc_g;
        stb_o      = cyc_g & stb_g;
        ack_v[gnt] = bus.wbs_ack_i;
        err_v[gnt] = bus.wbs_err_i;
        rty_v[gnt] = bus.wbs_rty_i;
        if (!cyc_g) begin
          ptr_n   = gnt_inc;
          state_n = ST_IDLE;
        end else if (stb_g && !term) begin
          // A termination in the limit cycle takes the other branch, so it wins.
          if (timeout != 0 && cnt == last_cnt) state_n = ST_ABORT;
          else                                 cnt_n   = cnt + 1'b1;
        end
      end
      ST_ABORT: begin
        err_v[gnt] = 1'b1;
        timeout_o  = 1'b1;
        state_n    = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!cyc_g) begin
          ptr_n   = gnt_inc;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_o = '0;
    if (state != ST_IDLE) grant_o[gnt] = 1'b1;
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: per-cycle vectors whose expected
// outputs go through a scoreboard queue and are compared on the falling edge.
module tb_wb_rr_arbiter;
  import wb_rr_arbiter_pkg::*;

  localparam logic [31:0] A0  = 32'h0000_0040;
  localparam logic [31:0] A1  = 32'h0000_0100;
  localparam logic [2:0]  NR  = 3'b000;
  localparam logic [2:0]  ACK = 3'b100;
  localparam logic [2:0]  ERR = 3'b010;
  localparam logic [2:0]  RTY = 3'b001;

  typedef struct {
    logic [1:0]  grant;
    logic        cyc, stb;
    logic [1:0]  ack, err, rty;
    logic        to;
    logic [31:0] adr;
    logic [31:0] sdat;
  } exp_t;

  typedef struct {
    logic        rst_n;
    logic [1:0]  cyc, stb;
    logic [2:0]  rsp;
    logic [31:0] adr0;
    logic [2:0]  cti;
    exp_t        e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant;
  logic       to;
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         step   = 0;
  exp_t       sb[$];
  vec_t       tbl[$];

  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.num_masters(2), .aw(32), .dw(32)) bus ();

  wb_rr_arbiter #(.num_masters(2), .aw(32), .dw(32), .timeout(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus),
    .grant_o    (grant),
    .timeout_o  (to)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @step %0d: got 0x%0h, want 0x%0h", name, step, act, exp);
    end
  endtask

  // Expected {cyc,stb} is passed as one 2-bit field.
  function automatic vec_t mk(input logic r, input logic [1:0] c, input logic [1:0] s,
                              input logic [2:0] rsp, input logic [31:0] a0, input logic [2:0] ct,
                              input logic [1:0] eg, input logic [1:0] ecs, input logic [1:0] ea,
                              input logic [1:0] ee, input logic [1:0] er, input logic eto,
                              input logic [31:0] eadr);
    vec_t v;
    v.rst_n = r;  v.cyc = c;  v.stb = s;  v.rsp = rsp;  v.adr0 = a0;  v.cti = ct;
    v.e.grant = eg;  v.e.cyc = ecs[1];  v.e.stb = ecs[0];
    v.e.ack = ea;  v.e.err = ee;  v.e.rty = er;  v.e.to = eto;  v.e.adr = eadr;
    v.e.sdat = '0;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    logic [31:0] sdat;
    @(posedge clk);
    #1;
    sdat          = $urandom;
    rst_n         = v.rst_n;
    bus.wbm_cyc_i = v.cyc;
    bus.wbm_stb_i = v.stb;
    bus.wbm_adr_i = {A1, v.adr0};
    bus.wbm_cti_i = {v.cti, v.cti};
    bus.wbs_ack_i = v.rsp[2];
    bus.wbs_err_i = v.rsp[1];
    bus.wbs_rty_i = v.rsp[0];
    bus.wbs_dat_i = sdat;
    e      = v.e;
    e.sdat = sdat;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("grant_o",   64'(grant),         64'(e.grant));
        check("wbs_cyc_o", 64'(bus.wbs_cyc_o), 64'(e.cyc));
        check("wbs_stb_o", 64'(bus.wbs_stb_o), 64'(e.stb));
        check("wbm_ack_o", 64'(bus.wbm_ack_o), 64'(e.ack));
        check("wbm_err_o", 64'(bus.wbm_err_o), 64'(e.err));
        check("wbm_rty_o", 64'(bus.wbm_rty_o), 64'(e.rty));
        check("timeout_o", 64'(to),            64'(e.to));
        check("wbs_adr_o", 64'(bus.wbs_adr_o), 64'(e.adr));
        check("wbm_dat_o", 64'(bus.wbm_dat_o), {e.sdat, e.sdat});
        step++;
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.wbm_adr_i = {A1, A0};
    bus.wbm_dat_i = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
    bus.wbm_sel_i = 8'hFF;
    bus.wbm_we_i  = 2'b10;
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    bus.wbm_cti_i = '0;
    bus.wbm_bte_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_ack_i = 1'b0;
    bus.wbs_err_i = 1'b0;
    bus.wbs_rty_i = 1'b0;
    fork monitor(); join_none

    // Reset, single master-1 classic read, then 4 contention rounds 0,1,0,1.
    tbl.push_back(mk(0, 2'b00, 2'b00, NR,  A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    tbl.push_back(mk(1, 2'b00, 2'b00, NR,  A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    tbl.push_back(mk(1, 2'b10, 2'b10, NR,  A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    tbl.push_back(mk(1, 2'b10, 2'b10, NR,  A0, CTI_CLASSIC, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(1, 2'b10, 2'b10, NR,  A0, CTI_CLASSIC, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(1, 2'b10, 2'b10, ACK, A0, CTI_CLASSIC, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(1, 2'b00, 2'b00, NR,  A0, CTI_CLASSIC, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(1, 2'b00, 2'b00, NR,  A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(0, 2'b00, 2'b00, NR,  A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(1, 2'b11, 2'b11, NR,  A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    tbl.push_back(mk(1, 2'b11, 2'b11, ACK, A0, CTI_CLASSIC, 2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 0, A0));
    tbl.push_back(mk(1, 2'b10, 2'b10, NR,  A0, CTI_CLASSIC, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    tbl.push_back(mk(1, 2'b11, 2'b11, NR,  A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    tbl.push_back(mk(1, 2'b11, 2'b11, ACK, A0, CTI_CLASSIC, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(1, 2'b01, 2'b01, NR,  A0, CTI_CLASSIC, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(1, 2'b11, 2'b11, NR,  A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(1, 2'b11, 2'b11, RTY, A0, CTI_CLASSIC, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 0, A0));
    tbl.push_back(mk(1, 2'b10, 2'b10, NR,  A0, CTI_CLASSIC, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    tbl.push_back(mk(1, 2'b11, 2'b11, NR,  A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    tbl.push_back(mk(1, 2'b11, 2'b11, ERR, A0, CTI_CLASSIC, 2'b10, 2'b11, 2'b00, 2'b10, 2'b00, 0, A1));
    tbl.push_back(mk(1, 2'b00, 2'b00, NR,  A0, CTI_CLASSIC, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(1, 2'b00, 2'b00, ACK, A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Burst hold: master 0 runs 4 INC beats (with one stb gap) while master 1 waits.
    begin
      int bt;
      logic [31:0] a;
      bt = 0;
      apply(mk(1, 2'b11, 2'b11, NR, 32'h200, CTI_INC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));
      for (int k = 0; k < 5; k++) begin
        a = 32'h200 + 32'(bt * 4);
        if (k == 2) begin
          apply(mk(1, 2'b11, 2'b10, NR, a, CTI_INC, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 0, a));
        end else begin
          apply(mk(1, 2'b11, 2'b11, ACK, a, (bt == 3) ? CTI_EOB : CTI_INC,
                   2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 0, a));
          bt++;
        end
      end
    end
    apply(mk(1, 2'b10, 2'b10, NR, A0, CTI_CLASSIC, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    apply(mk(1, 2'b10, 2'b10, NR, A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    apply(mk(1, 2'b10, 2'b10, NR, A0, CTI_CLASSIC, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 0, A1));
    apply(mk(1, 2'b00, 2'b00, NR, A0, CTI_CLASSIC, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));
    apply(mk(1, 2'b00, 2'b00, NR, A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));

    // Watchdog: 8 unanswered cycles, ABORT pulse, DRAIN until master 0 drops cyc.
    apply(mk(1, 2'b01, 2'b01, NR, A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));
    for (int i = 0; i < 8; i++)
      apply(mk(1, 2'b01, 2'b01, NR, A0, CTI_CLASSIC, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 0, A0));
    apply(mk(1, 2'b01, 2'b01, NR,  A0, CTI_CLASSIC, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1, A0));
    apply(mk(1, 2'b01, 2'b01, ACK, A0, CTI_CLASSIC, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    apply(mk(1, 2'b01, 2'b01, NR,  A0, CTI_CLASSIC, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    apply(mk(1, 2'b00, 2'b00, NR,  A0, CTI_CLASSIC, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    apply(mk(1, 2'b00, 2'b00, NR,  A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));

    // Ack in the 8th wait cycle beats the watchdog: no err, no timeout pulse.
    apply(mk(1, 2'b10, 2'b10, NR, A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    for (int i = 0; i < 8; i++)
      apply(mk(1, 2'b10, 2'b10, (i == 7) ? ACK : NR, A0, CTI_CLASSIC,
               2'b10, 2'b11, (i == 7) ? 2'b10 : 2'b00, 2'b00, 2'b00, 0, A1));
    apply(mk(1, 2'b10, 2'b10, NR, A0, CTI_CLASSIC, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 0, A1));
    apply(mk(1, 2'b00, 2'b00, NR, A0, CTI_CLASSIC, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));
    apply(mk(1, 2'b00, 2'b00, NR, A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));

    // Reset mid-burst: master 0 releases (pointer -> 1), master 1 bursts, reset on
    // beat 2; afterwards master 0 must win, proving the pointer went back to 0.
    apply(mk(1, 2'b01, 2'b01, NR,  A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A1));
    apply(mk(1, 2'b01, 2'b01, ACK, A0, CTI_CLASSIC, 2'b01, 2'b11, 2'b01, 2'b00, 2'b00, 0, A0));
    apply(mk(1, 2'b00, 2'b00, NR,  A0, CTI_CLASSIC, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    apply(mk(1, 2'b10, 2'b10, NR,  A0, CTI_INC,     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    apply(mk(1, 2'b10, 2'b10, ACK, A0, CTI_INC,     2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 0, A1));
    apply(mk(0, 2'b10, 2'b10, ACK, A0, CTI_INC,     2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 0, A1));
    apply(mk(1, 2'b11, 2'b11, ACK, A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    apply(mk(1, 2'b11, 2'b11, NR,  A0, CTI_CLASSIC, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 0, A0));
    apply(mk(1, 2'b00, 2'b00, NR,  A0, CTI_CLASSIC, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));
    apply(mk(1, 2'b00, 2'b00, NR,  A0, CTI_CLASSIC, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, A0));

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
